// File: rtl/riscv_defs.sv
// riscv_defs: shared definitions for the RV32I decode/issue slice.
//  - ALU op codes driven onto the EX stage op bus
//  - RV32I major opcode constants
//  - default bubble instruction (ADDI x0,x0,0)
//  - decoder result and ID/EX payload structs
//  - helper mapping funct3 to the ALU op shared by OP and OP-IMM
package riscv_defs;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_MUL   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_AUIPC = 4'd10;
    localparam logic [3:0] ALU_BEQ   = 4'd11;
    localparam logic [3:0] ALU_BLT   = 4'd12;
    localparam logic [3:0] ALU_BLTU  = 4'd13;
    localparam logic [3:0] ALU_SRA   = 4'd14;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Operand source selects produced by the decoder
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR, B_SHAMT} b_sel_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] imm;
        a_sel_e      a_sel;
        b_sel_e      b_sel;
        logic        br;
        logic        br_inv;
        logic [4:0]  rd;       // already forced to 0 when nothing is written
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        br;
        logic        br_inv;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } idex_t;

    // OP and OP-IMM share the funct3 -> ALU op assignment (funct7 variants
    // such as SUB/SRA are resolved by the caller).
    function automatic logic [3:0] alu_f3_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SHL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SHR;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: purely combinational RV32I instruction decoder.
//  Produces the ALU op, sign-extended immediate, operand source selects,
//  branch flags, destination register and illegal flag for one instruction.
// Ports:
//  instr_i  in   32  instruction word
//  dec_o    out  dec_t decoded fields (see riscv_defs)
// Configuration macro: ID_MUL_EN -- when defined, OP funct7=0x01 funct3=0
//  decodes as MUL; otherwise that encoding is reported illegal.
module rv32i_decoder
    import riscv_defs::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        wb;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    always_comb begin
        dec_o         = '0;
        dec_o.op      = ALU_ADD;
        dec_o.imm     = imm_i;
        dec_o.a_sel   = A_RS1;
        dec_o.b_sel   = B_IMM;
        wb            = 1'b0;

        case (opc)
            OPC_LUI: begin
                dec_o.a_sel = A_ZERO;
                dec_o.imm   = imm_u;
                wb          = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.a_sel = A_PC;
                dec_o.imm   = imm_u;
                dec_o.op    = ALU_AUIPC;
                wb          = 1'b1;
            end
            OPC_JAL: begin
                // ALU computes the link address pc+4; imm carries the target offset
                dec_o.a_sel = A_PC;
                dec_o.b_sel = B_FOUR;
                dec_o.imm   = imm_j;
                wb          = 1'b1;
            end
            OPC_JALR: begin
                dec_o.a_sel   = A_PC;
                dec_o.b_sel   = B_FOUR;
                wb            = 1'b1;
                dec_o.illegal = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_o.b_sel  = B_RS2;
                dec_o.imm    = imm_b;
                dec_o.br     = 1'b1;
                // Odd funct3 is the negated form of the even one below it
                dec_o.br_inv = f3[0];
                case (f3[2:1])
                    2'b00:   dec_o.op = ALU_BEQ;
                    2'b10:   dec_o.op = ALU_BLT;
                    2'b11:   dec_o.op = ALU_BLTU;
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                wb            = 1'b1;
                dec_o.illegal = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            OPC_STORE: begin
                dec_o.imm     = imm_s;
                dec_o.illegal = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                wb       = 1'b1;
                dec_o.op = alu_f3_op(f3);
                if (f3 == 3'd1) begin
                    dec_o.b_sel   = B_SHAMT;
                    dec_o.illegal = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    dec_o.b_sel = B_SHAMT;
                    if (f7 == 7'h20) begin
                        dec_o.op = ALU_SRA;
                    end else if (f7 != 7'h00) begin
                        dec_o.illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                wb          = 1'b1;
                dec_o.b_sel = B_RS2;
                dec_o.imm   = '0;
                if (f7 == 7'h00) begin
                    dec_o.op = alu_f3_op(f3);
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    dec_o.op = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    dec_o.op = ALU_SRA;
`ifdef ID_MUL_EN
                end else if (f7 == 7'h01 && f3 == 3'd0) begin
                    dec_o.op = ALU_MUL;
`endif
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            default: dec_o.illegal = 1'b1;
        endcase

        // Illegal instructions must not branch or write back
        if (dec_o.illegal) begin
            dec_o.op     = ALU_ADD;
            dec_o.br     = 1'b0;
            dec_o.br_inv = 1'b0;
            wb           = 1'b0;
        end

        dec_o.rd = wb ? instr_i[11:7] : 5'd0;
    end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: RV32I decode/issue stage feeding the ALU a/b/op interface.
//  Accepts instructions on a valid/ready handshake, decodes them, reads
//  the register file combinationally and registers operands/control in the
//  ID/EX register. Holds on backpressure, kills on flush.
// Ports:
//  clk, rst                     clock, synchronous active-high reset
//  in_valid/in_ready            fetch handshake; in_instr, in_pc payload
//  rs1_addr/rs2_addr            regfile read addresses (from in_instr)
//  rs1_data/rs2_data            regfile read data, same cycle
//  flush                        kill held and incoming instruction
//  out_valid/out_ready          EX handshake
//  out_a/out_b/out_op           ALU operands and op
//  out_br/out_br_inv/out_imm    branch control and immediate
//  out_rd/out_pc/out_illegal    writeback register, PC, illegal flag
// Configuration macro: ID_MUL_EN (enables MUL decode in rv32i_decoder).
module id_ex_issue
    import riscv_defs::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_op,
    output logic            out_br,
    output logic            out_br_inv,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    dec_t  dec_in;
    dec_t  dec_nop;
    idex_t idex_q, idex_d;
    logic  valid_q, valid_d;
    logic  load;

    rv32i_decoder u_dec (
        .instr_i (in_instr),
        .dec_o   (dec_in)
    );

    // Decoded bubble, written into the payload when a flush kills the slot
    rv32i_decoder u_nop_dec (
        .instr_i (NOP_INSTR),
        .dec_o   (dec_nop)
    );

    function automatic idex_t pack_idex(input dec_t        d,
                                        input logic [31:0] rs1_v,
                                        input logic [31:0] rs2_v,
                                        input logic [31:0] pc_v);
        idex_t p;
        p = '0;
        case (d.a_sel)
            A_PC:    p.a = pc_v;
            A_ZERO:  p.a = '0;
            default: p.a = rs1_v;
        endcase
        case (d.b_sel)
            B_RS2:   p.b = rs2_v;
            B_FOUR:  p.b = 32'd4;
            B_SHAMT: p.b = {27'b0, d.imm[4:0]};
            default: p.b = d.imm;
        endcase
        p.op      = d.op;
        p.br      = d.br;
        p.br_inv  = d.br_inv;
        p.imm     = d.imm;
        p.rd      = d.rd;
        p.pc      = pc_v;
        p.illegal = d.illegal;
        return p;
    endfunction

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // in_ready ignores flush: an instruction offered during flush counts as
    // consumed by fetch and is simply dropped here.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            idex_d  = pack_idex(dec_nop, 32'd0, 32'd0, 32'd0);
        end else if (load) begin
            valid_d = 1'b1;
            idex_d  = pack_idex(dec_in, rs1_data, rs2_data, in_pc);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = idex_q.a;
    assign out_b       = idex_q.b;
    assign out_op      = idex_q.op;
    assign out_br      = idex_q.br;
    assign out_br_inv  = idex_q.br_inv;
    assign out_imm     = idex_q.imm;
    assign out_rd      = idex_q.rd;
    assign out_pc      = idex_q.pc;
    assign out_illegal = idex_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
module tb_id_ex_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic        out_br, out_br_inv, out_illegal;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [31:0] out_a, out_b, out_imm, out_pc;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [3:0]  out_op;

    id_ex_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .out_br(out_br), .out_br_inv(out_br_inv), .out_imm(out_imm),
        .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
    );

`ifdef ID_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rf [32];

    typedef struct packed {
        logic [31:0] a, b, imm, pc;
        logic [3:0]  op;
        logic        br, inv, ill;
        logic [4:0]  rd;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ALU op by funct3 for the plain (funct7=0) arithmetic group
    function automatic int arith_op(input logic [2:0] f3);
        int t [8] = '{0, 6, 8, 9, 5, 7, 4, 3};
        return t[f3];
    endfunction

    // Branch op by funct3; -1 marks a reserved encoding
    function automatic int branch_op(input logic [2:0] f3);
        int t [8] = '{11, 11, -1, -1, 12, 12, 13, 13};
        return t[f3];
    endfunction

    // Reference: what the ID/EX register must hold after accepting ins
    function automatic exp_t ref_issue(input logic [31:0] ins, input logic [31:0] r1,
                                       input logic [31:0] r2, input logic [31:0] pc);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        bit wb;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'h000};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '0;
        e.pc = pc;
        wb = 1'b0;
        if (opc == 7'h37) begin
            e.a = 0; e.b = iu; e.imm = iu; wb = 1;
        end else if (opc == 7'h17) begin
            e.a = pc; e.b = iu; e.imm = iu; e.op = 10; wb = 1;
        end else if (opc == 7'h6F) begin
            e.a = pc; e.b = 4; e.imm = ij; wb = 1;
        end else if (opc == 7'h67) begin
            e.a = pc; e.b = 4; e.imm = ii; wb = 1; e.ill = (f3 != 0);
        end else if (opc == 7'h63) begin
            e.a = r1; e.b = r2; e.imm = ib;
            if (branch_op(f3) < 0) e.ill = 1;
            else begin
                e.op = 4'(branch_op(f3)); e.br = 1; e.inv = (f3 inside {1, 5, 7});
            end
        end else if (opc == 7'h03) begin
            e.a = r1; e.b = ii; e.imm = ii; wb = 1; e.ill = !(f3 inside {0, 1, 2, 4, 5});
        end else if (opc == 7'h23) begin
            e.a = r1; e.b = is; e.imm = is; e.ill = (f3 > 2);
        end else if (opc == 7'h13) begin
            e.a = r1; e.imm = ii; wb = 1;
            e.b = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : ii;
            e.op = (f3 == 5 && f7 == 7'h20) ? 4'd14 : 4'(arith_op(f3));
            if (f3 == 1) e.ill = (f7 != 0);
            if (f3 == 5) e.ill = !(f7 inside {7'h00, 7'h20});
        end else if (opc == 7'h33) begin
            e.a = r1; e.b = r2; e.imm = 0; wb = 1;
            if (f7 == 0) e.op = 4'(arith_op(f3));
            else if (f7 == 7'h20 && f3 == 0) e.op = 1;
            else if (f7 == 7'h20 && f3 == 5) e.op = 14;
            else if (f7 == 7'h01 && f3 == 0 && MUL_EN) e.op = 2;
            else e.ill = 1;
        end else begin
            e.ill = 1;
        end
        if (e.ill) begin
            e.op = 0; e.br = 0; e.inv = 0; wb = 0;
        end
        e.rd = (wb && ins[11:7] != 0) ? ins[11:7] : 5'd0;
        return e;
    endfunction

    // Model state, advanced on every active edge from the applied inputs
    bit   checking = 1'b0;
    bit   m_valid  = 1'b0;
    bit   m_zero   = 1'b0;
    exp_t m        = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_zero = 1; m = '0; checking = 1;
        end else if (flush) begin
            m_valid = 0; m_zero = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m = ref_issue(in_instr, rs1_data, rs2_data, in_pc);
            m_valid = 1; m_zero = 0;
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, in_instr[19:15]});
            chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, in_instr[24:20]});
            if (m_valid || m_zero) begin
                chk("out_op", {28'd0, out_op}, {28'd0, m.op});
                chk("out_rd", {27'd0, out_rd}, {27'd0, m.rd});
                chk("out_br", {31'd0, out_br}, {31'd0, m.br});
                chk("out_illegal", {31'd0, out_illegal}, {31'd0, m.ill});
                chk("out_pc", out_pc, m.pc);
                if (!m.ill) begin
                    chk("out_a", out_a, m.a);
                    chk("out_b", out_b, m.b);
                    chk("out_imm", out_imm, m.imm);
                    chk("out_br_inv", {31'd0, out_br_inv}, {31'd0, m.inv});
                end
            end
        end
    end

    // Apply one cycle of inputs, then wait until just after the edge that samples them
    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input logic [31:0] pc, input bit ordy, input bit fl);
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        rs1_data = rf[ins[19:15]];
        rs2_data = rf[ins[24:20]];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h13;
            8, 9: w[6:0] = 7'h33;
            default: ;
        endcase
        if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && (w[14:12] == 1 || w[14:12] == 5))) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_BNE  = 32'h0020_9463;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_MUL  = 32'h0220_81B3;

    initial begin
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 1; flush = 0;
        rs1_data = 0; rs2_data = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 0; rf[1] = 9; rf[2] = 4;

        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_ready", {31'd0, in_ready}, 1);
        chk("rst_a", out_a, 0);
        step(0, 0, 0, 0, 1, 0);

        step(0, 1, I_ADDI, 32'h100, 1, 0);
        chk("addi_valid", {31'd0, out_valid}, 1);
        chk("addi_a", out_a, 0);
        chk("addi_b", out_b, 5);
        chk("addi_op", {28'd0, out_op}, 0);
        chk("addi_rd", {27'd0, out_rd}, 1);

        step(0, 1, I_SUB, 32'h104, 1, 0);
        chk("sub_op", {28'd0, out_op}, 1);
        chk("sub_a", out_a, 9);
        chk("sub_b", out_b, 4);
        chk("sub_rd", {27'd0, out_rd}, 3);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, I_BNE, 32'h108, 0, 0);
            chk("stall_ready", {31'd0, in_ready}, 0);
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_op", {28'd0, out_op}, 1);
            chk("stall_a", out_a, 9);
            chk("stall_b", out_b, 4);
        end

        step(0, 1, I_BNE, 32'h108, 1, 0);
        chk("bne_op", {28'd0, out_op}, 11);
        chk("bne_br", {31'd0, out_br}, 1);
        chk("bne_inv", {31'd0, out_br_inv}, 1);
        chk("bne_imm", out_imm, 8);
        chk("bne_rd", {27'd0, out_rd}, 0);

        step(0, 1, I_LUI, 32'h10C, 1, 0);
        chk("lui_a", out_a, 0);
        chk("lui_b", out_b, 32'h1234_5000);
        chk("lui_op", {28'd0, out_op}, 0);
        chk("lui_rd", {27'd0, out_rd}, 5);

        step(0, 0, 0, 0, 0, 1);
        chk("flush_valid", {31'd0, out_valid}, 0);

        step(0, 1, I_MUL, 32'h110, 1, 0);
`ifdef ID_MUL_EN
        chk("mul_op", {28'd0, out_op}, 2);
        chk("mul_ill", {31'd0, out_illegal}, 0);
        chk("mul_rd", {27'd0, out_rd}, 3);
`else
        chk("mul_ill", {31'd0, out_illegal}, 1);
        chk("mul_rd", {27'd0, out_rd}, 0);
`endif

        step(0, 1, 32'hFFFF_FFFF, 32'h114, 1, 0);
        chk("ill_flag", {31'd0, out_illegal}, 1);
        chk("ill_rd", {27'd0, out_rd}, 0);
        chk("ill_op", {28'd0, out_op}, 0);
        chk("ill_br", {31'd0, out_br}, 0);

        step(0, 0, 0, 0, 0, 0);
        chk("hold_valid", {31'd0, out_valid}, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_valid", {31'd0, out_valid}, 0);

        chk("flushin_ready", {31'd0, in_ready}, 1);
        step(0, 1, I_ADDI, 32'h200, 1, 1);
        chk("flushin_valid", {31'd0, out_valid}, 0);

        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, ($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom & 32'hFFFF_FFFC), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0));
        end
        step(0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
